// File: rtl/serial_add_sub_8bit.sv
// -----------------------------------------------------------------------------
// serial_add_sub_8bit
//
// Bit-serial adder/subtractor. A single registered full-adder slice processes
// one operand bit per clock, LSB first, so a WIDTH-bit add or subtract takes
// WIDTH clocks after the operands are accepted.
//
// Subtraction is done as a + ~b + ~cin: operand B is inverted on accept and
// the carry register is seeded with cin^sub. The final carry is inverted back
// for subtraction, so cout reads as a borrow (1 when a < b + cin).
//
// Ports
//   clk    in   1      system clock, rising edge
//   rst    in   1      asynchronous, active-high reset
//   start  in   1      request, accepted when not busy (IDLE or DONE)
//   sub    in   1      0: add, 1: subtract (latched with start)
//   a      in   WIDTH  operand A, unsigned (latched with start)
//   b      in   WIDTH  operand B, unsigned (latched with start)
//   cin    in   1      carry-in (add) / borrow-in (sub) (latched with start)
//   s      out  WIDTH  result, valid from done until the next accepted start
//   cout   out  1      carry-out (add) / borrow-out (sub)
//   busy   out  1      high while the operation is running
//   done   out  1      one-cycle pulse, result valid
// -----------------------------------------------------------------------------
module serial_add_sub_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] bx_sh;   // B, already inverted for subtraction
    logic             sub_q;
    logic             carry;

    logic             sum_bit;
    logic             carry_next;

    function automatic logic majority(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // The full-adder slice always works on bit 0 of the shifting operands.
    assign sum_bit    = a_sh[0] ^ bx_sh[0] ^ carry;
    assign carry_next = majority(a_sh[0], bx_sh[0], carry);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            a_sh  <= '0;
            bx_sh <= '0;
            sub_q <= 1'b0;
            carry <= 1'b0;
            s     <= '0;
            cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        bx_sh <= b ^ {WIDTH{sub}};
                        sub_q <= sub;
                        carry <= cin ^ sub;
                        count <= '0;
                        s     <= '0;
                        cout  <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    // start is deliberately not looked at here: no queueing.
                    a_sh  <= a_sh >> 1;
                    bx_sh <= bx_sh >> 1;
                    carry <= carry_next;
                    // Shift in from the MSB side so bit k ends at s[k] after WIDTH shifts.
                    s     <= {sum_bit, s[WIDTH-1:1]};
                    if (count == LAST_BIT) begin
                        cout  <= carry_next ^ sub_q;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sub_8bit.sv
// -----------------------------------------------------------------------------
// tb_serial_add_sub_8bit
//
// Directed bench for serial_add_sub_8bit: reset state, add/sub vectors with
// hand-computed results, ignored re-start while running, asynchronous abort,
// and a back-to-back sweep checked against a behavioural arithmetic model.
// -----------------------------------------------------------------------------
module tb_serial_add_sub_8bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       cout;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    serial_add_sub_8bit #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .s     (s),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Run one operation. Cycle 0 is the first falling edge after the accept
    // edge; done must appear at cycle 8 with busy high in cycles 0..7.
    // If repulse_at >= 0, start is pulsed with different operands at that cycle.
    task automatic do_op(input string tag, input logic op_sub, input logic [7:0] op_a,
                         input logic [7:0] op_b, input logic op_cin,
                         input logic [7:0] exp_s, input logic exp_c, input int repulse_at);
        int cyc;
        int busy_cnt;
        @(negedge clk);
        sub = op_sub; a = op_a; b = op_b; cin = op_cin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        busy_cnt = 0;
        while (!done && cyc < 20) begin
            if (busy) busy_cnt++;
            if (cyc == repulse_at) begin
                start = 1'b1; a = 8'd1; b = 8'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, "_latency"}, cyc, 8);
        check({tag, "_busy_cycles"}, busy_cnt, 8);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 0);
        check({tag, "_s"}, {24'd0, s}, {24'd0, exp_s});
        check({tag, "_cout"}, {31'd0, cout}, {31'd0, exp_c});
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, done}, 0);
        check({tag, "_s_hold"}, {24'd0, s}, {24'd0, exp_s});
    endtask

    initial begin
        int cyc;
        int done_cnt;
        int idx;
        logic [8:0] ref_sum;
        logic [7:0] exp_s;
        logic       exp_c;

        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_s", {24'd0, s}, 0);
        check("rst_cout", {31'd0, cout}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        rst = 1'b0;

        // Directed add / sub vectors.
        do_op("add_100_55",   1'b0, 8'd100, 8'd55,  1'b0, 8'd155, 1'b0, -1);
        do_op("add_200_100c", 1'b0, 8'd200, 8'd100, 1'b1, 8'd45,  1'b1, -1);
        do_op("add_255_255c", 1'b0, 8'd255, 8'd255, 1'b1, 8'd255, 1'b1, -1);
        do_op("sub_100_55",   1'b1, 8'd100, 8'd55,  1'b0, 8'd45,  1'b0, -1);
        do_op("sub_5_10",     1'b1, 8'd5,   8'd10,  1'b0, 8'd251, 1'b1, -1);
        do_op("sub_0_0b",     1'b1, 8'd0,   8'd0,   1'b1, 8'd255, 1'b1, -1);

        // start re-pulsed mid-run must not disturb the operation.
        do_op("repulse_9_9",  1'b0, 8'd9,   8'd9,   1'b0, 8'd18,  1'b0, 3);

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        sub = 1'b0; a = 8'd77; b = 8'd66; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_busy_before", {31'd0, busy}, 1);
        #2 rst = 1'b1;
        #1;
        check("abort_s", {24'd0, s}, 0);
        check("abort_cout", {31'd0, cout}, 0);
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_done", {31'd0, done}, 0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        do_op("after_abort", 1'b0, 8'd17, 8'd25, 1'b1, 8'd43, 1'b0, -1);

        // Back-to-back sweep with start held high through every DONE cycle.
        idx = 0;
        @(negedge clk);
        start = 1'b1;
        for (int sb = 0; sb < 2; sb++) begin
            for (int ci = 0; ci < 2; ci++) begin
                for (int ia = 0; ia < 10; ia++) begin
                    for (int ib = 0; ib < 10; ib++) begin
                        sub = sb[0]; cin = ci[0]; a = ia[7:0]; b = ib[7:0];
                        if (sb == 0) begin
                            ref_sum = 9'(ia + ib + ci);
                            exp_s   = ref_sum[7:0];
                            exp_c   = ref_sum[8];
                        end else begin
                            exp_s   = 8'(ia - ib - ci);
                            exp_c   = (ia < ib + ci);
                        end
                        @(negedge clk);
                        cyc = 0;
                        while (!done && cyc < 20) begin
                            @(negedge clk);
                            cyc++;
                        end
                        check($sformatf("b2b_%0d_latency", idx), cyc, 8);
                        check($sformatf("b2b_%0d_s", idx), {24'd0, s}, {24'd0, exp_s});
                        check($sformatf("b2b_%0d_cout", idx), {31'd0, cout}, {31'd0, exp_c});
                        idx++;
                    end
                end
            end
        end
        start = 1'b0;
        @(negedge clk);
        check("b2b_end_idle_busy", {31'd0, busy}, 0);
        check("b2b_end_idle_done", {31'd0, done}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
